// File: rtl/mdu_iterative.sv
`default_nettype none
// ============================================================================
// Module  : mdu_iterative
// Brief   : Iterative unsigned multiply/divide unit (MUL, MULHU, DIVU, REMU)
//           feeding the register bank write port.
// Revision: 1.0 - initial release
// ============================================================================
module mdu_iterative #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       rd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_out,
    output logic             we_reg
);

    localparam int             c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [c_CW-1:0]   r_count;
    logic [1:0]        r_op;
    logic [WIDTH-1:0]  r_b;
    logic [4:0]        r_rd;
    logic [WIDTH-1:0]  r_hi;
    logic [WIDTH-1:0]  r_lo;
    logic [WIDTH-1:0]  r_result;
    logic [4:0]        r_rd_out;
    logic              r_done;
    logic              r_we;

    logic              w_accept;
    logic              w_last;
    logic [WIDTH:0]    w_sum;
    logic [WIDTH:0]    w_add;
    logic [WIDTH:0]    w_shift;
    logic [WIDTH:0]    w_trial;
    logic [WIDTH-1:0]  w_hi_next;
    logic [WIDTH-1:0]  w_lo_next;
    logic [WIDTH-1:0]  w_res_next;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_state == S_CALC) && (r_count == c_LAST);

    // Multiply: r_hi is the upper product half, r_lo holds the multiplier
    // and collects the low product bits as the register shifts right.
    assign w_sum = {1'b0, r_hi} + {1'b0, r_b};
    assign w_add = r_lo[0] ? w_sum : {1'b0, r_hi};

    // Divide: r_hi is the partial remainder, r_lo the dividend/quotient.
    // The borrow out of the 65-bit trial subtract is the restore decision.
    assign w_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_b};

    always_comb begin
        w_hi_next = w_add[WIDTH:1];
        w_lo_next = {w_add[0], r_lo[WIDTH-1:1]};
        if (r_op[1]) begin
            w_hi_next = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
            w_lo_next = {r_lo[WIDTH-2:0], ~w_trial[WIDTH]};
        end
    end

    always_comb begin
        w_res_next = w_lo_next;
        case (r_op)
            2'b01:   w_res_next = w_hi_next;
            2'b11:   w_res_next = w_hi_next;
            default: w_res_next = w_lo_next;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_CALC;
            S_CALC:  if (r_count == c_LAST) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_op     <= '0;
            r_b      <= '0;
            r_rd     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_rd_out <= '0;
            r_done   <= 1'b0;
            r_we     <= 1'b0;
        end else begin
            r_done <= w_last;
            r_we   <= w_last && (r_rd != 5'd0);
            if (w_accept) begin
                r_count <= '0;
                r_op    <= op;
                r_b     <= b;
                r_rd    <= rd;
                r_hi    <= '0;
                r_lo    <= a;
            end else if (r_state == S_CALC) begin
                r_count <= r_count + 1'b1;
                r_hi    <= w_hi_next;
                r_lo    <= w_lo_next;
            end
            // Result and destination only change on completion, so they
            // hold stable between operations.
            if (w_last) begin
                r_result <= w_res_next;
                r_rd_out <= r_rd;
            end
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign we_reg = r_we;
    assign result = r_result;
    assign rd_out = r_rd_out;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iterative.sv
`default_nettype none
// ============================================================================
// Module  : tb_mdu_iterative
// Brief   : Scoreboard testbench for mdu_iterative.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic [4:0]  rd_out;
    logic        we_reg;

    mdu_iterative #(.WIDTH(64)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .rd     (rd),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out),
        .we_reg (we_reg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        logic [127:0] p;
        p = {64'd0, x} * {64'd0, y};
        case (o)
            2'b00:   return p[63:0];
            2'b01:   return p[127:64];
            2'b10:   return (y == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : x / y;
            default: return (y == 64'd0) ? x : x % y;
        endcase
    endfunction

    // Every done/we_reg pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && (done || we_reg)) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                m_e = sb.pop_front();
                check("result", result, m_e.res);
                check("rd_out", 64'(rd_out), 64'(m_e.rd));
                check("we_reg", 64'(we_reg), 64'(m_e.we));
                check("done",   64'(done), 64'd1);
            end
        end
    end

    // inj_at: cycle after acceptance at which a competing start is pulsed.
    // rst_at: cycle after acceptance at which reset aborts the request.
    task automatic run_op(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                          input logic [4:0] r, input int inj_at, input int rst_at);
        exp_t e;
        int   lat;
        e.res = model(o, x, y);
        e.rd  = r;
        e.we  = (r != 5'd0);
        sb.push_back(e);
        start = 1'b1; op = o; a = x; b = y; rd = r;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom}; rd = 5'($urandom);
        check("busy_after_accept", 64'(busy), 64'd1);
        lat = 0;
        while (1) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            rst   = 1'b0;
            if (done) break;
            if (lat == inj_at) begin
                start = 1'b1; op = ~o; a = ~x; b = y + 64'd3; rd = r + 5'd1;
            end
            if (lat == rst_at) begin
                sb.delete();
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                check("abort_busy",   64'(busy), 64'd0);
                check("abort_done",   64'(done), 64'd0);
                check("abort_we",     64'(we_reg), 64'd0);
                check("abort_result", result, 64'd0);
                repeat (80) @(negedge clk);
                return;
            end
            if (lat > 200) begin
                check("timeout", 64'(lat), 64'd64);
                return;
            end
        end
        check("latency", 64'(lat), 64'd64);
        @(negedge clk);
        check("busy_after_done", 64'(busy), 64'd0);
        check("done_one_cycle",  64'(done), 64'd0);
        check("result_hold",     result, e.res);
        check("rd_out_hold",     64'(rd_out), 64'(e.rd));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0; rd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rst_busy",   64'(busy), 64'd0);
            check("rst_done",   64'(done), 64'd0);
            check("rst_we",     64'(we_reg), 64'd0);
            check("rst_result", result, 64'd0);
            check("rst_rd_out", 64'(rd_out), 64'd0);
            @(negedge clk);
        end

        run_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, -1, -1);
        run_op(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, -1, -1);
        run_op(2'b10, 64'd100, 64'd7, 5'd3, -1, -1);
        run_op(2'b11, 64'd100, 64'd7, 5'd3, -1, -1);
        run_op(2'b10, 64'h1234, 64'd0, 5'd9, -1, -1);
        run_op(2'b11, 64'h1234, 64'd0, 5'd9, -1, -1);
        run_op(2'b00, 64'd12345, 64'd678, 5'd7, 10, -1);
        run_op(2'b10, 64'd99, 64'd10, 5'd0, -1, -1);
        run_op(2'b00, 64'hDEAD_BEEF, 64'h1_0000, 5'd4, -1, 30);
        run_op(2'b11, 64'hFFFF_FFFF_0000_0001, 64'hFFFF, 5'd31, -1, -1);
        for (int i = 0; i < 8; i++) begin
            logic [63:0] x, y;
            x = {$urandom, $urandom};
            y = (i % 2 == 0) ? {$urandom, $urandom} : 64'($urandom);
            run_op(2'(i), x, y, 5'($urandom_range(0, 31)), -1, -1);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
